// File: rtl/dcp_pkg.sv
// dcp_pkg: shared FSM state enum and egress beat record for the arbiter
package dcp_pkg;
  localparam int DW_MAX = 64;
  localparam int AW_MAX = 16;
  typedef enum logic {IDLE, GRANT} state_t;
  typedef struct packed {
    logic [AW_MAX-1:0] dst;
    logic [DW_MAX-1:0] pld;
    logic              last;
  } beat_t;
endpackage

// File: rtl/dcp_rr_pick.sv
// dcp_rr_pick: combinational round-robin pick; req/ptr in, one-hot win and any out
module dcp_rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic          any
);
  always_comb begin
    win = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N]) win = N'(1) << ((int'(ptr) + i) % N);
  end
  assign any = |req;
endmodule

// File: rtl/dcp_arb_unit.sv
// dcp_arb_unit: RNUM-way packet round-robin arbiter with 2-entry egress FIFO; iClk/iRst, per-requester req handshake, single egress handshake, oGrant/oBusy status
module dcp_arb_unit
  import dcp_pkg::*;
#(
  parameter int DW   = 16,
  parameter int AW   = 4,
  parameter int RNUM = 4
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic [RNUM-1:0]   iReqVld,
  output logic [RNUM-1:0]   oReqRdy,
  input  logic [RNUM*DW-1:0] iReqPld,
  input  logic [RNUM*AW-1:0] iReqDst,
  input  logic [RNUM-1:0]   iReqLast,
  output logic              oOutVld,
  input  logic              iOutRdy,
  output logic [DW-1:0]     oOutPld,
  output logic [AW-1:0]     oOutDst,
  output logic              oOutLast,
  output logic [RNUM-1:0]   oGrant,
  output logic              oBusy
);
  localparam int PW = $clog2(RNUM);
  state_t state, nxt;
  logic [PW-1:0] ptr, gidx, widx;
  logic [RNUM-1:0] win;
  logic any, push, pop, last_in;
  beat_t mem [2];
  logic wp, rp;
  logic [1:0] cnt;
  dcp_rr_pick #(.N(RNUM)) u_pick (.req(iReqVld), .ptr(ptr), .win(win), .any(any));
  assign oReqRdy  = cnt == 2'd2 ? '0 : oGrant;
  assign push     = |(iReqVld & oReqRdy);
  assign pop      = oOutVld & iOutRdy;
  assign last_in  = iReqLast[gidx];
  assign oOutVld  = cnt != 2'd0;
  assign oOutPld  = DW'(mem[rp].pld);
  assign oOutDst  = AW'(mem[rp].dst);
  assign oOutLast = mem[rp].last;
  assign oBusy    = state == GRANT || oOutVld;
  always_comb begin
    widx = '0;
    for (int i = 0; i < RNUM; i++)
      if (win[i]) widx = PW'(i);
  end
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (any ? GRANT : IDLE) : (push && last_in ? IDLE : GRANT);
  end
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state  <= IDLE;
      oGrant <= '0;
      gidx   <= '0;
      ptr    <= '0;
      cnt    <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE) begin
        oGrant <= win;
        gidx   <= widx;
      end else if (push && last_in) begin
        oGrant <= '0;
        ptr    <= gidx == PW'(RNUM - 1) ? '0 : gidx + 1'b1;
      end
      if (push) begin
        mem[wp] <= '{dst: AW_MAX'(iReqDst[gidx*AW +: AW]), pld: DW_MAX'(iReqPld[gidx*DW +: DW]), last: last_in};
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_dcp_arb_unit.sv
// tb_dcp_arb_unit: table vectors, directed corner sequences and random traffic checked against a queue model
module tb_dcp_arb_unit;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req_vld, req_rdy, req_last, gnt;
  logic [63:0] req_pld;
  logic [15:0] req_dst;
  logic out_vld, out_rdy, out_last, busy;
  logic [15:0] out_pld;
  logic [3:0] out_dst;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  dcp_arb_unit #(.DW(16), .AW(4), .RNUM(4)) dut (
    .iClk(clk), .iRst(rst), .iReqVld(req_vld), .oReqRdy(req_rdy),
    .iReqPld(req_pld), .iReqDst(req_dst), .iReqLast(req_last),
    .oOutVld(out_vld), .iOutRdy(out_rdy), .oOutPld(out_pld),
    .oOutDst(out_dst), .oOutLast(out_last), .oGrant(gnt), .oBusy(busy)
  );
  typedef struct {
    logic [15:0] pld;
    logic [3:0]  dst;
    logic        last;
  } mbeat_t;
  int owner = -1;
  int mptr = 0;
  mbeat_t q[$];
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic cycle(input bit chk_en);
    logic [3:0] eg;
    mbeat_t b;
    bit push, pop;
    #2;
    if (chk_en) begin
      eg = owner < 0 ? 4'b0 : 4'(1 << owner);
      check("grant", gnt, eg);
      check("req_rdy", req_rdy, (owner >= 0 && q.size() < 2) ? eg : 4'b0);
      check("out_vld", out_vld, q.size() != 0);
      check("busy", busy, owner >= 0 || q.size() != 0);
      if (q.size() != 0) begin
        check("out_pld", out_pld, q[0].pld);
        check("out_dst", out_dst, q[0].dst);
        check("out_last", out_last, q[0].last);
      end
    end
    @(posedge clk);
    if (rst) begin
      owner = -1;
      mptr = 0;
      q.delete();
    end else begin
      push = owner >= 0 && q.size() < 2 && req_vld[owner];
      pop = q.size() != 0 && out_rdy;
      if (owner >= 0) b = '{req_pld[owner*16 +: 16], req_dst[owner*4 +: 4], req_last[owner]};
      if (pop) void'(q.pop_front());
      if (push) q.push_back(b);
      if (owner < 0) begin
        for (int i = 0; i < 4; i++)
          if (owner < 0 && req_vld[(mptr + i) % 4]) owner = (mptr + i) % 4;
      end else if (push && b.last) begin
        mptr = (owner + 1) % 4;
        owner = -1;
      end
    end
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    req_vld = '0;
    req_last = '0;
    out_rdy = 1'b1;
    cycle(1);
    rst = 1'b0;
  endtask
  typedef struct {
    bit rst; logic [3:0] vld; logic [15:0] pld; bit last; bit ordy;
    logic [3:0] e_gnt; logic [3:0] e_rdy; bit e_vld; logic [15:0] e_pld;
    logic [3:0] e_dst; bit e_last; bit e_busy;
  } vec_t;
  vec_t tbl[11];
  int seq[9];
  int exp_seq[9];
  initial begin
    tbl = '{
      '{1'b1, 4'b0000, 16'h0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0},
      '{1'b0, 4'b0001, 16'h0011, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0},
      '{1'b0, 4'b0001, 16'h0011, 1'b0, 1'b1, 4'b0001, 4'b0001, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b1},
      '{1'b0, 4'b0001, 16'h0022, 1'b0, 1'b1, 4'b0001, 4'b0001, 1'b1, 16'h0011, 4'h1, 1'b0, 1'b1},
      '{1'b0, 4'b0001, 16'h0033, 1'b1, 1'b1, 4'b0001, 4'b0001, 1'b1, 16'h0022, 4'h1, 1'b0, 1'b1},
      '{1'b0, 4'b0000, 16'h0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1, 16'h0033, 4'h1, 1'b1, 1'b1},
      '{1'b0, 4'b0000, 16'h0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0},
      '{1'b0, 4'b0011, 16'h0055, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0},
      '{1'b0, 4'b0011, 16'h0055, 1'b1, 1'b1, 4'b0010, 4'b0010, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b1},
      '{1'b0, 4'b0000, 16'h0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1, 16'h0055, 4'h2, 1'b1, 1'b1},
      '{1'b0, 4'b0000, 16'h0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0}
    };
    exp_seq = '{1, 0, 2, 0, 4, 0, 8, 0, 1};
    rst = 1'b1;
    req_vld = '0;
    req_last = '0;
    req_pld = '0;
    req_dst = 16'h4321;
    out_rdy = 1'b1;
    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      rst = tbl[i].rst;
      req_vld = tbl[i].vld;
      req_pld = {4{tbl[i].pld}};
      req_last = {4{tbl[i].last}};
      out_rdy = tbl[i].ordy;
      #2;
      check($sformatf("t%0d_grant", i), gnt, tbl[i].e_gnt);
      check($sformatf("t%0d_rdy", i), req_rdy, tbl[i].e_rdy);
      check($sformatf("t%0d_ovld", i), out_vld, tbl[i].e_vld);
      check($sformatf("t%0d_busy", i), busy, tbl[i].e_busy);
      if (tbl[i].e_vld) begin
        check($sformatf("t%0d_opld", i), out_pld, tbl[i].e_pld);
        check($sformatf("t%0d_odst", i), out_dst, tbl[i].e_dst);
        check($sformatf("t%0d_olast", i), out_last, tbl[i].e_last);
      end
      cycle(1);
    end
    do_reset();
    req_vld = 4'b1111;
    req_last = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      req_pld = {$urandom, $urandom};
      cycle(1);
      seq[i] = int'(gnt);
    end
    foreach (seq[i]) check($sformatf("rr_order%0d", i), seq[i], exp_seq[i]);
    do_reset();
    req_vld = 4'b0100;
    req_last = 4'b0000;
    req_pld = {$urandom, $urandom};
    cycle(1);
    cycle(1);
    req_vld = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      cycle(1);
      check("hold_grant", gnt, 4'b0100);
      check("hold_rdy0", req_rdy[0], 1'b0);
    end
    req_vld = 4'b0101;
    req_last = 4'b0100;
    cycle(1);
    check("hold_release", gnt, 4'b0000);
    req_vld = 4'b0001;
    req_last = 4'b0001;
    cycle(1);
    check("hold_next", gnt, 4'b0001);
    cycle(1);
    do_reset();
    req_vld = 4'b0001;
    req_last = 4'b0000;
    out_rdy = 1'b0;
    req_pld[15:0] = 16'hA001;
    cycle(1);
    cycle(1);
    req_pld[15:0] = 16'hA002;
    cycle(1);
    check("full_rdy", req_rdy, 4'b0000);
    check("full_pld", out_pld, 16'hA001);
    req_pld[15:0] = 16'hA003;
    cycle(1);
    cycle(1);
    check("stall_pld", out_pld, 16'hA001);
    out_rdy = 1'b1;
    cycle(1);
    cycle(1);
    req_pld[15:0] = 16'hA004;
    req_last = 4'b0001;
    cycle(1);
    req_vld = 4'b0000;
    for (int i = 0; i < 3; i++) cycle(1);
    do_reset();
    req_vld = 4'b0001;
    req_last = 4'b0000;
    cycle(1);
    cycle(1);
    rst = 1'b1;
    cycle(1);
    check("rst_ovld", out_vld, 1'b0);
    check("rst_grant", gnt, 4'b0000);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    req_vld = 4'b1000;
    req_last = 4'b1000;
    cycle(1);
    check("rst_req3", gnt, 4'b1000);
    cycle(1);
    do_reset();
    req_vld = 4'b0010;
    req_last = 4'b0010;
    cycle(1);
    cycle(1);
    req_vld = 4'b1010;
    req_last = 4'b1010;
    cycle(1);
    check("ptr2_win3", gnt, 4'b1000);
    cycle(1);
    cycle(1);
    check("ptr0_win1", gnt, 4'b0010);
    cycle(1);
    for (int i = 0; i < 400; i++) begin
      rst = $urandom_range(0, 49) == 0;
      req_vld = 4'($urandom);
      req_pld = {$urandom, $urandom};
      req_dst = 16'($urandom);
      req_last = 4'($urandom & $urandom);
      out_rdy = $urandom_range(0, 3) != 0;
      cycle(1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dcp_arb_unit.md
DCP_ARB_UNIT -- requirements
Module: dcp_arb_unit

Interface
REQ-001 Parameter DW, default 16: payload width in bits.
REQ-002 Parameter AW, default 4: destination field width in bits.
REQ-003 Parameter RNUM, default 4: number of requesters; legal range 2..16.
REQ-004 iClk  input  1  sole clock; all state updates on rising edge.
REQ-005 iRst  input  1  reset; synchronous and active-high.
REQ-006 iReqVld  input  RNUM  per-requester beat valid.
REQ-007 oReqRdy  output  RNUM  per-requester beat ready.
REQ-008 iReqPld  input  RNUM*DW  payloads; requester k occupies bits [k*DW +: DW].
REQ-009 iReqDst  input  RNUM*AW  destinations; requester k occupies bits [k*AW +: AW].
REQ-010 iReqLast  input  RNUM  last beat of packet; sampled only on a transfer.
REQ-011 oOutVld / iOutRdy  output / input  1 / 1  egress handshake.
REQ-012 oOutPld / oOutDst / oOutLast  output  DW / AW / 1  egress beat.
REQ-013 oGrant  output  RNUM  one-hot current owner; all zero in IDLE.
REQ-014 oBusy  output  1  high when the FSM is in GRANT or the egress buffer is non-empty.

Function
REQ-015 A transfer occurs on any port in a cycle where its Vld and Rdy are both high.
REQ-016 The FSM has two states: IDLE and GRANT.
REQ-017 IDLE: when any iReqVld is high, register the winner into oGrant and go to GRANT on the next edge; otherwise stay in IDLE.
REQ-018 The winner is the first requester with Vld high, searching upward from pointer rr_ptr with wrap-around modulo RNUM.
REQ-019 In IDLE, all oReqRdy bits are 0.
REQ-020 GRANT: oReqRdy[g] = buffer-not-full for the owner g; every other oReqRdy bit is 0.
REQ-021 GRANT: on a transfer with iReqLast=1, go to IDLE and set rr_ptr = (g+1) mod RNUM.
REQ-022 If the owner drops Vld mid-packet, ownership is held and the FSM stays in GRANT; no other requester is served.
REQ-023 Grant latency is 1 cycle from request to GRANT entry.
REQ-024 There is one idle cycle between the last beat of one packet and the first beat of the next.
REQ-025 The egress buffer is a 2-entry FIFO.
REQ-026 oReqRdy shall not combinationally depend on iOutRdy.
REQ-027 Egress latency: a beat accepted at edge N is visible on the egress outputs after edge N.
REQ-028 Sustained throughput is 1 beat/cycle while iOutRdy=1.
REQ-029 Buffer full: ready deasserts.
REQ-030 Buffer empty: oOutVld=0.
REQ-031 Simultaneous push and pop while the buffer holds 1 entry: occupancy stays 1 and order is preserved.
REQ-032 The buffer keeps data stable while oOutVld=1 and iOutRdy=0.
REQ-033 Pld, Dst and Last pass unmodified; no width conversion.

Reset
REQ-034 When iRst=1 at an edge, the following are cleared: FSM=IDLE, rr_ptr=0, oGrant=0, buffer empty.
REQ-035 During and after reset, oOutVld=0, oReqRdy=0 and oBusy=0.
REQ-036 Reset mid-packet discards buffered beats and the partial packet; the first post-reset arbitration starts at requester 0.
REQ-037 Reset takes priority over any simultaneous transfer.

Structure
REQ-038 Package dcp_pkg shall hold the FSM state enum (IDLE, GRANT) and the egress beat struct {Dst, Pld, Last}.
REQ-039 One sub-module, dcp_rr_pick, shall implement the combinational round-robin pick.
REQ-040 dcp_rr_pick I/O: request vector and pointer in; one-hot winner and any-request flag out.
REQ-041 The FSM, rr_ptr and the 2-entry buffer reside in dcp_arb_unit.

Verification
REQ-042 Reset release, then iReqVld=4'b0001 with a 3-beat packet (Pld 0x11, 0x22, 0x33; Last on 0x33) -> oGrant=0001 one cycle after request; the three beats appear in order; rr_ptr=1 afterwards.
REQ-043 All four requesters present 1-beat packets continuously from reset -> grant order 0,1,2,3,0; one bubble cycle between consecutive grants.
REQ-044 Owner 2 drops Vld for 3 cycles mid-packet while requester 0 is valid -> oGrant stays 0100 and oReqRdy[0]=0 until owner 2's Last beat is transferred.
REQ-045 iOutRdy=0 for 5 cycles during a 4-beat packet -> buffer fills to 2, oReqRdy[g]=0, no beat is lost or duplicated, and oOutPld is held stable.
REQ-046 Assert iRst in the 2nd beat of a packet -> next cycle oOutVld=0, oGrant=0 and oBusy=0; a subsequent request from requester 3 alone is granted.
REQ-047 Requesters 1 and 3 valid with rr_ptr=2 -> requester 3 wins; after its Last beat, requester 1 wins.
